pmu_dump_serializer: RTL and testbench
======================================

Name: pmu_dump_serializer

Overview:
- Reader side of the cache performance-counter interface. On request, it captures a snapshot of NUM_CNT 32-bit event counters and streams them out as a framed byte sequence.
- Uses a valid/ready byte handshake to feed the debug/host byte channel (UART TX or trace FIFO).
- The snapshot decouples the frame contents from counters that keep incrementing during transmission.

Parameters:
- NUM_CNT, 6, number of 32-bit counters captured per frame (1..16).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- cnt_in  input  NUM_CNT*32  flattened live counter values; counter k occupies bits [32k+31:32k].
- dump_req  input  1  single-cycle request to snapshot and transmit.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts the byte (transfer when out_valid && out_ready).
- out_data  output  8  frame byte.
- out_last  output  1  high with the final (checksum) byte of the frame.
- busy  output  1  frame in progress (state != IDLE).
- req_dropped  output  1  one-cycle pulse when dump_req arrives while busy.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, req_dropped=0. State=IDLE, byte index=0, checksum=0, snapshot=0.
- Frame format: HEADER, then counter 0..NUM_CNT-1, each sent as 4 bytes little-endian (LSB first), then one checksum byte. Total 4*NUM_CNT+2 bytes (26 at default).
- Checksum: XOR of all 4*NUM_CNT payload bytes. HEADER is excluded.
- States: IDLE, HDR, DATA, CSUM.
- IDLE:
  - If dump_req is seen at edge t, the snapshot register captures cnt_in at that same edge, and the state goes to HDR.
  - out_valid=1 with out_data=HEADER from cycle t+1.
  - busy=1 from cycle t+1.
- HDR: on handshake, go to DATA with byte index=0 and checksum=0.
- DATA:
  - out_data = byte (index mod 4) of snapshot word (index / 4).
  - On each handshake: checksum ^= out_data and index += 1.
  - After the handshake of index 4*NUM_CNT-1, go to CSUM.
- CSUM: out_data=checksum, out_last=1. On handshake, go to IDLE, with out_valid=0 and busy=0 in the following cycle.
- Handshake rules:
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid never drops before the transfer completes.
  - out_valid is independent of out_ready (no combinational ready->valid path).
- Throughput: one byte per cycle when out_ready is held high, so a default frame takes 26 cycles.
- dump_req when state != IDLE, including the cycle of the final CSUM handshake:
  - req_dropped=1 in the next cycle.
  - Snapshot and frame are unaffected.
  - The request is not queued.
- Snapshot is immutable for the whole frame regardless of cnt_in changes.
- Byte index width is clog2(4*NUM_CNT). It never wraps within a frame.
- rst mid-frame: the frame is abandoned, and all outputs return to reset values in the next cycle. No partial-frame resume.
- rst and dump_req in the same cycle: rst wins, and no frame starts.

Test Plan:
- cnt_in[31:0]=0x11223344, other counters 0, dump_req pulse, out_ready=1 -> bytes A5,44,33,22,11, then 20×00, then checksum 0x44 with out_last=1. Exactly 26 consecutive transfers; busy low afterwards.
- Same frame with out_ready toggled randomly (~50%) -> identical byte sequence; out_data stable during every valid&&!ready cycle.
- Start a frame, then increment every counter by 1 each cycle during transmission -> frame contains the values at the request edge only; checksum matches the snapshot.
- dump_req pulses mid-frame and in the final CSUM handshake cycle -> req_dropped pulses once per request; no second frame; busy drops after the first frame.
- Assert rst after 10 transferred bytes -> out_valid=0 and busy=0 the next cycle. A new dump_req then yields a full frame starting with A5.
- All counters 0xFFFFFFFF -> payload 24×FF, checksum 0x00 (even count of FF).

Source files
------------

// File: rtl/pmu_dump_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pmu_dump_serializer
// Brief    : Snapshots NUM_CNT 32-bit event counters on request and streams
//            them as a framed, XOR-checksummed byte sequence over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_dump_serializer #(
    parameter int          NUM_CNT = 6,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CNT*32-1:0]  cnt_in,
    input  logic                   dump_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   req_dropped
);

    localparam int                 NUM_BYTES = 4 * NUM_CNT;
    localparam int                 IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [NUM_CNT*32-1:0]  snap_q, snap_d;
    logic                   dropped_q, dropped_d;

    logic [7:0]             w_bytes [NUM_BYTES];
    logic [7:0]             w_cur_byte;
    logic                   w_xfer;

    // Flattened counters are little-endian per word, so payload byte i is bits [8i+7:8i].
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_bytes
        assign w_bytes[i] = snap_q[8*i +: 8];
    end

    assign w_cur_byte = w_bytes[idx_q];
    assign w_xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            csum_q    <= '0;
            snap_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            snap_q    <= snap_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        snap_d    = snap_q;
        dropped_d = dump_req && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    snap_d  = cnt_in;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    idx_d   = '0;
                    csum_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    csum_d = csum_q ^ w_cur_byte;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, so ready never combinationally reaches valid.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER;
            end
            ST_DATA: begin
                out_valid = 1'b1;
                out_data  = w_cur_byte;
            end
            ST_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign req_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_pmu_dump_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmu_dump_serializer
// Brief    : Scoreboard bench for pmu_dump_serializer frame streaming.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmu_dump_serializer;

    localparam int          N   = 6;
    localparam logic [7:0]  HDR = 8'hA5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*32-1:0] cnt_in;
    logic           dump_req;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     out_data;
    logic           out_last;
    logic           busy;
    logic           req_dropped;

    int             errors = 0;
    int             checks = 0;
    int             xfer_count = 0;
    logic [8:0]     sb [$];

    bit             stall_q = 1'b0;
    logic [7:0]     prev_data;
    logic           prev_last;

    pmu_dump_serializer #(.NUM_CNT(N), .HEADER(HDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .dump_req    (dump_req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                xfer_count++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got data=%h last=%b, required no transfer", out_data, out_last);
                end else begin
                    logic [8:0] exp;
                    exp = sb.pop_front();
                    if ({out_last, out_data} !== exp) begin
                        errors++;
                        $display("FAIL frame_byte: got last=%b data=%h, required last=%b data=%h",
                                 out_last, out_data, exp[8], exp[7:0]);
                    end
                end
            end
            stall_q   = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    task automatic push_frame(input logic [N*32-1:0] v);
        logic [7:0] cs;
        cs = 8'h00;
        sb.push_back({1'b0, HDR});
        for (int i = 0; i < 4*N; i++) begin
            sb.push_back({1'b0, v[8*i +: 8]});
            cs = cs ^ v[8*i +: 8];
        end
        sb.push_back({1'b1, cs});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the frame to drain; optionally randomises ready and keeps counters moving.
    task automatic wait_frame_done(input int max_cycles, input bit rand_ready,
                                   input bit bump, output bit ok);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < max_cycles) begin
            tick();
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (bump) for (int k = 0; k < N; k++) cnt_in[32*k +: 32] = cnt_in[32*k +: 32] + 32'd1;
            n++;
        end
        ok = (busy === 1'b0) && (sb.size() == 0);
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dump_req = 1'b0; out_ready = 1'b1; cnt_in = '0;
        repeat (3) tick();
        checks++;
        if ({out_valid, out_data, out_last, busy, req_dropped} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b busy=%b dropped=%b, required all 0",
                     out_valid, out_data, out_last, busy, req_dropped);
        end
        dump_req = 1'b1; cnt_in = {N{32'hDEADBEEF}};
        tick();
        dump_req = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_req: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [N*32-1:0] v;
        int n;
        v = '0; v[31:0] = 32'h11223344;
        cnt_in = v; dump_req = 1'b1; out_ready = 1'b1;
        push_frame(v);
        tick();
        dump_req = 1'b0; cnt_in = '0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4*N+2 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_frame_cycles: got %0d cycles with %0d bytes pending, required %0d and 0",
                     n, sb.size(), 4*N+2);
        end
    endtask

    task automatic test_backpressure();
        logic [N*32-1:0] v;
        bit ok;
        v = '0; v[31:0] = 32'h11223344;
        cnt_in = v; dump_req = 1'b1;
        push_frame(v);
        tick();
        dump_req = 1'b0;
        wait_frame_done(400, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_done: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_snapshot();
        logic [N*32-1:0] v;
        bit ok;
        for (int k = 0; k < N; k++) v[32*k +: 32] = 32'h1000_00F0 * (k + 1) + 32'hFE;
        cnt_in = v; dump_req = 1'b1;
        push_frame(v);
        tick();
        dump_req = 1'b0;
        wait_frame_done(200, 1'b0, 1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL snapshot_done: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_dropped();
        logic [N*32-1:0] v;
        int n;
        int extra;
        for (int k = 0; k < N; k++) v[32*k +: 32] = $urandom;
        cnt_in = v; dump_req = 1'b1; out_ready = 1'b1;
        push_frame(v);
        tick();
        dump_req = 1'b0;
        repeat (5) tick();
        dump_req = 1'b1; cnt_in = ~v;
        tick();
        dump_req = 1'b0;
        checks++;
        if (req_dropped !== 1'b1) begin
            errors++;
            $display("FAIL drop_mid_pulse: got %b, required 1", req_dropped);
        end
        tick();
        checks++;
        if (req_dropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_mid_clear: got %b, required 0", req_dropped);
        end
        n = 0;
        while (out_last !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        checks++;
        if (req_dropped !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_csum: dropped=%b busy=%b, required 1 0", req_dropped, busy);
        end
        extra = 0;
        repeat (6) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0 || req_dropped !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drop_no_second_frame: %0d active cycles, %0d pending, required 0 0", extra, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [N*32-1:0] v;
        int base;
        int n;
        bit ok;
        for (int k = 0; k < N; k++) v[32*k +: 32] = 32'h0102_0304 << k;
        cnt_in = v; dump_req = 1'b1; out_ready = 1'b1;
        push_frame(v);
        base = xfer_count;
        tick();
        dump_req = 1'b0;
        n = 0;
        while (xfer_count < base + 10 && n < 60) begin
            tick();
            n++;
        end
        rst = 1'b1; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%h last=%b, required 0 0 00 0",
                     out_valid, busy, out_data, out_last);
        end
        rst = 1'b0; out_ready = 1'b1;
        sb.delete();
        tick();
        v = ~v;
        cnt_in = v; dump_req = 1'b1;
        push_frame(v);
        tick();
        dump_req = 1'b0;
        wait_frame_done(200, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset_frame: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_all_ones();
        bit ok;
        cnt_in = {N{32'hFFFF_FFFF}}; dump_req = 1'b1; out_ready = 1'b1;
        push_frame(cnt_in);
        tick();
        dump_req = 1'b0;
        wait_frame_done(400, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL all_ones_done: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_dropped();
        test_mid_reset();
        test_all_ones();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
